// File: rtl/hld_multi.sv
// hld_multi: harmonic-lock detector for the FMDLL delay line.
// Optional `HLD_EVENT_CNT_EN adds the saturating hld_events counter.
module hld_multi #(
    parameter int NTAPS   = 10,
    parameter int CONFIRM = 4,
    parameter int HOLDOFF = 16
) (
    input  logic                     clk_ext,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NTAPS-1:0]         q,
    output logic                     hld1,
    output logic                     hld2,
    output logic                     reset_pd,
    output logic                     locked,
    output logic [$clog2(NTAPS)-1:0] edge_cnt
`ifdef HLD_EVENT_CNT_EN
    ,
    output logic [7:0]               hld_events
`endif
);

    localparam int EW = $clog2(NTAPS);
    localparam int CW = $clog2(CONFIRM + 1);
    localparam int HW = $clog2(HOLDOFF + 1);

    localparam logic [CW-1:0] C_CONF = CW'(CONFIRM);
    localparam logic [CW-1:0] C_LAST = CW'(CONFIRM - 1);
    localparam logic [HW-1:0] C_HOLD = HW'(HOLDOFF);
    localparam logic [HW-1:0] C_HONE = HW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MONITOR = 2'd1,
        S_HARM    = 2'd2,
        S_STUCK   = 2'd3
    } state_t;

    state_t          r_state;
    logic [NTAPS-1:0] r_q_s;
    logic            r_qs_vld;
    logic            r_ec_vld;
    logic [EW-1:0]   r_ecnt;
    logic [CW-1:0]   r_hcnt;
    logic [CW-1:0]   r_zcnt;
    logic [CW-1:0]   r_lcnt;
    logic [HW-1:0]   r_hocnt;
    logic            r_hld1;
    logic            r_hld2;
    logic            r_rpd;
    logic            r_locked;

    logic [EW-1:0]   w_ecnt;
    logic            w_is_zero;
    logic            w_is_one;
    logic            w_is_harm;
    logic            w_consume;
    logic            w_hit_h;
    logic            w_hit_z;

    // Count 0->1 steps going up the tap index of the captured vector
    always_comb begin
        w_ecnt = '0;
        for (int i = 0; i < NTAPS - 1; i++) begin
            if (!r_q_s[i] && r_q_s[i+1]) begin
                w_ecnt = w_ecnt + EW'(1);
            end
        end
    end

    assign w_is_zero = (r_ecnt == '0);
    assign w_is_one  = (r_ecnt == EW'(1));
    assign w_is_harm = !w_is_zero && !w_is_one;

    // Count is only meaningful once the two pipeline stages hold real samples
    assign w_consume = en && r_ec_vld && (r_state == S_MONITOR);
    assign w_hit_h   = w_consume && w_is_harm && (r_hcnt == C_LAST);
    assign w_hit_z   = w_consume && w_is_zero && (r_zcnt == C_LAST);

    // Input capture and transition-count pipeline; runs regardless of en
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            r_q_s    <= '0;
            r_ecnt   <= '0;
            r_qs_vld <= 1'b0;
            r_ec_vld <= 1'b0;
        end else begin
            r_q_s    <= q;
            r_ecnt   <= w_ecnt;
            r_qs_vld <= 1'b1;
            r_ec_vld <= r_qs_vld;
        end
    end

    // Detector FSM with run counters, holdoff timer and registered flags
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_zcnt   <= '0;
            r_lcnt   <= '0;
            r_hocnt  <= '0;
            r_hld1   <= 1'b0;
            r_hld2   <= 1'b0;
            r_rpd    <= 1'b0;
            r_locked <= 1'b0;
        end else if (!en) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_zcnt   <= '0;
            r_lcnt   <= '0;
            r_hocnt  <= '0;
            r_hld1   <= 1'b0;
            r_hld2   <= 1'b0;
            r_rpd    <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_MONITOR;
                    r_hcnt  <= '0;
                    r_zcnt  <= '0;
                    r_lcnt  <= '0;
                end
                S_MONITOR: begin
                    if (r_ec_vld) begin
                        if (w_is_harm) begin
                            r_zcnt   <= '0;
                            r_lcnt   <= '0;
                            r_locked <= 1'b0;
                            if (w_hit_h) begin
                                r_state <= S_HARM;
                                r_hld1  <= 1'b1;
                                r_rpd   <= 1'b1;
                                r_hocnt <= C_HOLD;
                                r_hcnt  <= '0;
                            end else begin
                                r_hcnt <= r_hcnt + CW'(1);
                            end
                        end else if (w_is_zero) begin
                            r_hcnt   <= '0;
                            r_lcnt   <= '0;
                            r_locked <= 1'b0;
                            if (w_hit_z) begin
                                r_state <= S_STUCK;
                                r_hld2  <= 1'b1;
                                r_rpd   <= 1'b1;
                                r_hocnt <= C_HOLD;
                                r_zcnt  <= '0;
                            end else begin
                                r_zcnt <= r_zcnt + CW'(1);
                            end
                        end else begin
                            r_hcnt <= '0;
                            r_zcnt <= '0;
                            if (r_lcnt != C_CONF) begin
                                r_lcnt <= r_lcnt + CW'(1);
                            end
                            if (r_lcnt == C_LAST) begin
                                r_locked <= 1'b1;
                            end
                        end
                    end
                end
                S_HARM, S_STUCK: begin
                    if (r_hocnt == C_HONE) begin
                        r_state <= S_MONITOR;
                        r_hocnt <= '0;
                        r_hcnt  <= '0;
                        r_zcnt  <= '0;
                        r_lcnt  <= '0;
                        r_hld1  <= 1'b0;
                        r_hld2  <= 1'b0;
                        r_rpd   <= 1'b0;
                    end else begin
                        r_hocnt <= r_hocnt - HW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign hld1     = r_hld1;
    assign hld2     = r_hld2;
    assign reset_pd = r_rpd;
    assign locked   = r_locked;
    assign edge_cnt = r_ecnt;

`ifdef HLD_EVENT_CNT_EN
    logic [7:0] r_events;

    // Saturating tally of flag events; only rst clears it
    always_ff @(posedge clk_ext or posedge rst) begin
        if (rst) begin
            r_events <= '0;
        end else if ((w_hit_h || w_hit_z) && (r_events != 8'hFF)) begin
            r_events <= r_events + 8'd1;
        end
    end

    assign hld_events = r_events;
`endif

endmodule
